controlador_entrada_saida: RTL and testbench

CONTROLADOR_ENTRADA_SAIDA -- requirements
Module: controlador_entrada_saida

---
 rtl/controlador_entrada_saida_if.sv | 33 +++
 rtl/controlador_entrada_saida.sv | 129 ++++++++++++
 tb/tb_controlador_entrada_saida.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_entrada_saida_if.sv
// Processor-side bus of the IN/OUT controller: instruction requests, switch
// and button inputs, stall request and the output channel registers.
interface controlador_entrada_saida_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = 14,
    parameter int unsigned N_OUT      = 4
);
    localparam int unsigned CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                        in;
    logic                        out;
    logic [CW-1:0]               canal;
    logic [DATA_WIDTH-1:0]       resultado_ula;
    logic [IN_WIDTH-1:0]         dado_lido_entrada;
    logic                        botao_confirma;
    logic                        parar;
    logic                        dado_pronto;
    logic [DATA_WIDTH-1:0]       dado_entrada;
    logic [N_OUT*DATA_WIDTH-1:0] saidas;
    logic [N_OUT-1:0]            saida_atualizada;

    // Processor / board side.
    modport master (
        output in, out, canal, resultado_ula, dado_lido_entrada, botao_confirma,
        input  parar, dado_pronto, dado_entrada, saidas, saida_atualizada
    );

    // Controller side.
    modport slave (
        input  in, out, canal, resultado_ula, dado_lido_entrada, botao_confirma,
        output parar, dado_pronto, dado_entrada, saidas, saida_atualizada
    );
endinterface

// File: rtl/controlador_entrada_saida.sv
// IN/OUT controller: IN stalls the processor until the confirm button is
// pressed (synchronized and debounced), then captures the switches; OUT writes
// one of N_OUT channel registers in a single cycle without stalling.
module controlador_entrada_saida #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = 14,
    parameter int unsigned N_OUT      = 4,
    parameter int unsigned DEBOUNCE   = 4
) (
    input logic                       clock,
    input logic                       reset_n,
    controlador_entrada_saida_if.slave bus
);
    localparam int unsigned CW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned DBW = $clog2(DEBOUNCE + 1);
    // N_OUT in CW+1 bits so that canal can be range-checked without truncation.
    localparam logic [CW:0] N_OUT_W = (CW + 1)'(N_OUT);

    typedef enum logic [1:0] {StOcioso, StEspera, StCaptura} state_e;

    state_e                             r_state, w_state_next;
    logic [1:0]                         r_btn_sync;
    logic [IN_WIDTH-1:0]                r_sw_meta, r_sw_sync;
    logic [DBW-1:0]                     r_db_cnt, w_db_cnt_inc;
    logic                               r_confirmado, r_confirmado_prev;
    logic                               w_conf_rise;
    logic                               w_write_ok;
    logic [DATA_WIDTH-1:0]              r_dado_entrada;
    logic                               r_dado_pronto;
    logic [N_OUT-1:0][DATA_WIDTH-1:0]   r_saidas;
    logic [N_OUT-1:0]                   r_saida_atualizada;

    // Two-flop synchronizers for the asynchronous button and switches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_sync <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_btn_sync <= {r_btn_sync[0], bus.botao_confirma};
            r_sw_meta  <= bus.dado_lido_entrada;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // Saturating count of consecutive high cycles of the synchronized button.
    assign w_db_cnt_inc = (r_db_cnt == DBW'(DEBOUNCE)) ? r_db_cnt : r_db_cnt + DBW'(1);

    // Debounce filter: confirmado rises after DEBOUNCE high cycles, drops on any low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_db_cnt          <= '0;
            r_confirmado      <= 1'b0;
            r_confirmado_prev <= 1'b0;
        end else begin
            r_confirmado_prev <= r_confirmado;
            if (!r_btn_sync[1]) begin
                r_db_cnt     <= '0;
                r_confirmado <= 1'b0;
            end else begin
                r_db_cnt     <= w_db_cnt_inc;
                r_confirmado <= (w_db_cnt_inc == DBW'(DEBOUNCE));
            end
        end
    end

    // Only a fresh press counts: a button already held needs release and re-press.
    assign w_conf_rise = r_confirmado & ~r_confirmado_prev;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StOcioso;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; in/out are only decoded while idle.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StOcioso:  if (bus.in) w_state_next = StEspera;
            StEspera:  if (w_conf_rise) w_state_next = StCaptura;
            StCaptura: w_state_next = StOcioso;
            default:   w_state_next = StOcioso;
        endcase
    end

    // IN capture and its one-cycle ready strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dado_entrada <= '0;
            r_dado_pronto  <= 1'b0;
        end else begin
            r_dado_pronto <= (r_state == StCaptura);
            if (r_state == StCaptura) begin
                r_dado_entrada <= DATA_WIDTH'(r_sw_sync);
            end
        end
    end

    // IN has priority over OUT; out-of-range channels are silently dropped.
    assign w_write_ok = (r_state == StOcioso) && !bus.in && bus.out &&
                        ({1'b0, bus.canal} < N_OUT_W);

    // OUT channel registers and their one-cycle write strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_saidas           <= '0;
            r_saida_atualizada <= '0;
        end else begin
            r_saida_atualizada <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                if (w_write_ok && (bus.canal == CW'(k))) begin
                    r_saidas[k]           <= bus.resultado_ula;
                    r_saida_atualizada[k] <= 1'b1;
                end
            end
        end
    end

    // Stall is combinational on in while idle so the IN instruction holds at once.
    assign bus.parar            = reset_n & ((r_state != StOcioso) | bus.in);
    assign bus.dado_pronto      = r_dado_pronto;
    assign bus.dado_entrada     = r_dado_entrada;
    assign bus.saidas           = r_saidas;
    assign bus.saida_atualizada = r_saida_atualizada;
endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Bench for controlador_entrada_saida: OUT vector table, IN/debounce sequences,
// priority, held-button, out-of-range channel and mid-wait reset cases.
module tb_controlador_entrada_saida;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 14;
    localparam int unsigned NO = 4;
    localparam int unsigned DB = 4;
    localparam int          LAT = 2 + DB + 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    controlador_entrada_saida_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .N_OUT(NO)) bus ();
    controlador_entrada_saida_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .N_OUT(3))  bus3 ();

    controlador_entrada_saida #(
        .DATA_WIDTH(DW), .IN_WIDTH(IW), .N_OUT(NO), .DEBOUNCE(DB)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    controlador_entrada_saida #(
        .DATA_WIDTH(DW), .IN_WIDTH(IW), .N_OUT(3), .DEBOUNCE(DB)
    ) dut3 (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus3)
    );

    typedef struct {
        bit          is_in;
        int          ch;
        logic [31:0] value;
    } exp_t;

    typedef struct {
        logic        out;
        logic [1:0]  canal;
        logic [31:0] data;
        logic [3:0]  exp_strobe;
        logic        exp_parar;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_item;
    vec_t        vecs[6];
    logic [31:0] mdl[NO];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Waits up to max_cyc falling edges for dado_pronto; reports parar along the way.
    task automatic wait_pronto(input int max_cyc, output int lat, output bit seen,
                               output bit stall_all);
        seen      = 1'b0;
        lat       = -1;
        stall_all = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clock);
            if (bus.dado_pronto) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
            if (!bus.parar) stall_all = 1'b0;
        end
    endtask

    task automatic start_in(input logic [IW-1:0] sw, input string name);
        bus.dado_lido_entrada = sw;
        bus.in = 1'b1;
        #1;
        check({name, "_parar_comb"}, bus.parar, 1);
        tick(1);
        bus.in = 1'b0;
        #1;
        check({name, "_parar_espera"}, bus.parar, 1);
    endtask

    // Scoreboard monitor: every strobe must match the oldest pending expectation.
    always @(negedge clock) begin
        if (reset_n && (bus.dado_pronto || bus.saida_atualizada != '0)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {bus.dado_pronto, bus.saida_atualizada}, 0);
            end else begin
                mon_item = sb.pop_front();
                if (mon_item.is_in) begin
                    check("sb_dado_pronto", bus.dado_pronto, 1);
                    check("sb_dado_entrada", bus.dado_entrada, mon_item.value);
                    check("sb_no_out_strobe", bus.saida_atualizada, 0);
                end else begin
                    check("sb_out_strobe", bus.saida_atualizada, 4'b0001 << mon_item.ch);
                    check("sb_saida_value", bus.saidas[mon_item.ch*DW +: DW], mon_item.value);
                    check("sb_no_pronto", bus.dado_pronto, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        bit seen;
        bit stall_all;

        vecs[0] = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b0100, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 32'h11111111, 4'b0001, 1'b0};
        vecs[2] = '{1'b1, 2'd3, 32'hA5A5A5A5, 4'b1000, 1'b0};
        vecs[3] = '{1'b1, 2'd1, 32'h00000000, 4'b0010, 1'b0};
        vecs[4] = '{1'b0, 2'd1, 32'hFFFFFFFF, 4'b0000, 1'b0};
        vecs[5] = '{1'b1, 2'd2, 32'h12345678, 4'b0100, 1'b0};
        for (int k = 0; k < NO; k++) mdl[k] = '0;

        bus.in = 1'b1;
        bus.out = 1'b0;
        bus.canal = '0;
        bus.resultado_ula = '0;
        bus.dado_lido_entrada = '0;
        bus.botao_confirma = 1'b0;
        bus3.in = 1'b0;
        bus3.out = 1'b0;
        bus3.canal = '0;
        bus3.resultado_ula = '0;
        bus3.dado_lido_entrada = '0;
        bus3.botao_confirma = 1'b0;

        // Reset state, with in asserted to show parar is masked.
        #12;
        check("rst_parar", bus.parar, 0);
        check("rst_dado_pronto", bus.dado_pronto, 0);
        check("rst_dado_entrada", bus.dado_entrada, 0);
        check("rst_saidas", bus.saidas[63:0] | bus.saidas[127:64], 0);
        check("rst_saida_atualizada", bus.saida_atualizada, 0);
        bus.in = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick(2);

        // OUT vector table.
        for (int i = 0; i < 6; i++) begin
            bus.out = vecs[i].out;
            bus.canal = vecs[i].canal;
            bus.resultado_ula = vecs[i].data;
            #1;
            check($sformatf("vec%0d_parar", i), bus.parar, vecs[i].exp_parar);
            if (vecs[i].exp_strobe != '0) begin
                sb.push_back('{1'b0, int'(vecs[i].canal), vecs[i].data});
                mdl[vecs[i].canal] = vecs[i].data;
            end
            tick(1);
            bus.out = 1'b0;
            @(negedge clock);
            check($sformatf("vec%0d_strobe", i), bus.saida_atualizada, vecs[i].exp_strobe);
            check($sformatf("vec%0d_parar_after", i), bus.parar, 0);
            tick(1);
            check($sformatf("vec%0d_strobe_cleared", i), bus.saida_atualizada, 0);
        end
        for (int k = 0; k < NO; k++) begin
            check($sformatf("hold_ch%0d", k), bus.saidas[k*DW +: DW], mdl[k]);
        end

        // Out-of-range channel on a 3-channel instance, then a valid write.
        bus3.out = 1'b1;
        bus3.canal = 2'd3;
        bus3.resultado_ula = 32'hBAADF00D;
        tick(1);
        bus3.canal = 2'd2;
        bus3.resultado_ula = 32'h0000C0DE;
        @(negedge clock);
        check("oor_no_strobe", bus3.saida_atualizada, 0);
        check("oor_no_change", bus3.saidas, 0);
        tick(1);
        bus3.out = 1'b0;
        @(negedge clock);
        check("n3_ch2_strobe", bus3.saida_atualizada, 3'b100);
        check("n3_ch2_value", bus3.saidas[2*DW +: DW], 32'h0000C0DE);
        tick(1);

        // Basic IN with clean 10-cycle press and minimum latency.
        start_in(14'h2A5F, "in1");
        bus.botao_confirma = 1'b1;
        sb.push_back('{1'b1, 0, 32'h00002A5F});
        wait_pronto(20, lat, seen, stall_all);
        check("in1_seen", seen, 1);
        check("in1_latency", lat, LAT);
        check("in1_stalled", stall_all, 1);
        check("in1_parar_released", bus.parar, 0);
        tick(1);
        check("in1_pronto_one_cycle", bus.dado_pronto, 0);
        check("in1_value_held", bus.dado_entrada, 32'h00002A5F);
        tick(1);
        bus.botao_confirma = 1'b0;
        tick(4);

        // Bouncing button never confirms; a clean press then does.
        start_in(14'h1234, "bnc");
        for (int r = 0; r < 5; r++) begin
            bus.botao_confirma = 1'b1;
            tick(3);
            bus.botao_confirma = 1'b0;
            tick(1);
        end
        check("bnc_still_stalled", bus.parar, 1);
        bus.botao_confirma = 1'b1;
        sb.push_back('{1'b1, 0, 32'h00001234});
        wait_pronto(20, lat, seen, stall_all);
        check("bnc_seen", seen, 1);
        check("bnc_latency", lat, LAT);
        tick(1);
        bus.botao_confirma = 1'b0;
        tick(4);

        // IN and OUT together: IN wins, no write.
        bus.out = 1'b1;
        bus.canal = 2'd0;
        bus.resultado_ula = 32'hCAFEF00D;
        start_in(14'h0FFF, "pri");
        bus.out = 1'b0;
        @(negedge clock);
        check("pri_no_strobe", bus.saida_atualizada, 0);
        check("pri_ch0_kept", bus.saidas[0 +: DW], mdl[0]);
        tick(1);
        // OUT while waiting is ignored.
        bus.out = 1'b1;
        bus.canal = 2'd1;
        bus.resultado_ula = 32'h0BADC0DE;
        tick(1);
        bus.out = 1'b0;
        @(negedge clock);
        check("esp_out_no_strobe", bus.saida_atualizada, 0);
        check("esp_out_ch1_kept", bus.saidas[DW +: DW], mdl[1]);
        tick(1);
        bus.botao_confirma = 1'b1;
        sb.push_back('{1'b1, 0, 32'h00000FFF});
        wait_pronto(20, lat, seen, stall_all);
        check("pri_seen", seen, 1);
        tick(1);
        bus.botao_confirma = 1'b0;
        tick(4);

        // Button held before IN requires release and re-press.
        bus.botao_confirma = 1'b1;
        tick(8);
        start_in(14'h3C3C, "held");
        wait_pronto(12, lat, seen, stall_all);
        check("held_no_capture", seen, 0);
        check("held_stalled", stall_all, 1);
        tick(1);
        bus.botao_confirma = 1'b0;
        tick(3);
        bus.botao_confirma = 1'b1;
        sb.push_back('{1'b1, 0, 32'h00003C3C});
        wait_pronto(20, lat, seen, stall_all);
        check("held_repress_seen", seen, 1);
        check("held_repress_latency", lat, LAT);
        tick(1);
        bus.botao_confirma = 1'b0;
        tick(4);

        // Reset pulse while waiting aborts the IN.
        start_in(14'h1111, "rstw");
        tick(2);
        bus.in = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("rstw_parar", bus.parar, 0);
        check("rstw_saidas", bus.saidas[63:0] | bus.saidas[127:64], 0);
        check("rstw_dado_entrada", bus.dado_entrada, 0);
        check("rstw_dado_pronto", bus.dado_pronto, 0);
        check("rstw_strobe", bus.saida_atualizada, 0);
        @(posedge clock);
        #1;
        bus.in = 1'b0;
        reset_n = 1'b1;
        tick(1);
        check("rstw_idle", bus.parar, 0);
        bus.botao_confirma = 1'b1;
        wait_pronto(20, lat, seen, stall_all);
        check("rstw_no_capture", seen, 0);
        check("rstw_parar_after", bus.parar, 0);
        tick(1);
        bus.botao_confirma = 1'b0;
        tick(2);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
